mem_bus_arbiter: RTL

Parametrised shared-memory arbiter for the pipelined core: merges CH independent memory request channels onto one registered, variable-latency memory bus. Channel 0 is instruction fetch and channel 1 is the MEM stage; further channels serve additional masters. Per-channel stall requests feed the stall controller. A bus watchdog terminates hung transactions with an error.

---
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter merging CH request channels onto one registered,
// variable-latency memory bus, with a watchdog that ends hung transactions.
module mem_bus_arbiter #(
  parameter int CH = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TO = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         req_ce,
  input  logic [CH-1:0]         req_we,
  input  logic [CH*AW-1:0]      req_addr,
  input  logic [CH*(DW/8)-1:0]  req_sel,
  input  logic [CH*DW-1:0]      req_wdata,
  output logic [CH-1:0]         req_ack,
  output logic                  req_err,
  output logic [DW-1:0]         req_rdata,
  output logic [CH-1:0]         stallreq,
  output logic                  bus_ce,
  output logic                  bus_we,
  output logic [AW-1:0]         bus_addr,
  output logic [DW/8-1:0]       bus_sel,
  output logic [DW-1:0]         bus_wdata,
  input  logic [DW-1:0]         bus_rdata,
  input  logic                  bus_ack
);

  localparam int SW = DW / 8;
  localparam int LW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW = (TO > 1) ? $clog2(TO + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TO > 0) ? CW'(TO - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   last, last_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            bus_ce_nxt, bus_we_nxt;
  logic [AW-1:0]   bus_addr_nxt;
  logic [SW-1:0]   bus_sel_nxt;
  logic [DW-1:0]   bus_wdata_nxt;
  logic [CH-1:0]   req_ack_nxt;
  logic            req_err_nxt;
  logic [DW-1:0]   req_rdata_nxt;

  logic            excl;
  logic            pick_vld;
  logic [LW-1:0]   pick;
  logic            timeout;
  logic            load;

  function automatic logic [LW-1:0] wrap_add(input logic [LW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return LW'(sum % CH);
  endfunction

  assign stallreq = req_ce & ~req_ack;
  assign timeout  = (TO != 0) && (cnt >= TO_LAST);
  // Outside IDLE the channel just served (last) must not win again immediately.
  assign excl     = (state != IDLE);

  // Offset 1 from last has top priority, so it is assigned last in the scan.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last;
    for (int k = CH; k >= 1; k--) begin
      if (req_ce[wrap_add(last, k)] && !(excl && (k == CH))) begin
        pick_vld = 1'b1;
        pick     = wrap_add(last, k);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    cnt_nxt       = cnt;
    bus_ce_nxt    = bus_ce;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_sel_nxt   = bus_sel;
    bus_wdata_nxt = bus_wdata;
    req_ack_nxt   = '0;
    req_err_nxt   = 1'b0;
    req_rdata_nxt = req_rdata;
    load          = 1'b0;

    if (bus_ce && (TO != 0) && !timeout) cnt_nxt = cnt + 1'b1;

    unique case (state)
      IDLE: load = pick_vld;
      BUSY: begin
        if (bus_ack || timeout) begin
          req_ack_nxt[last] = 1'b1;
          req_err_nxt       = !bus_ack;
          if (bus_ack && !bus_we) req_rdata_nxt = bus_rdata;
          bus_ce_nxt        = 1'b0;
          state_nxt         = DONE;
          // Next grant goes out with the ack so the bus sees no idle turnaround.
          load              = pick_vld;
        end
      end
      DONE: begin
        if (bus_ce)        state_nxt = BUSY;
        else if (pick_vld) load      = 1'b1;
        else               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      last_nxt      = pick;
      cnt_nxt       = '0;
      bus_ce_nxt    = 1'b1;
      bus_we_nxt    = req_we[pick];
      bus_addr_nxt  = req_addr[pick*AW +: AW];
      bus_sel_nxt   = req_sel[pick*SW +: SW];
      bus_wdata_nxt = req_wdata[pick*DW +: DW];
      if (state != BUSY) state_nxt = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= LW'(CH - 1);
      cnt       <= '0;
      bus_ce    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      req_ack   <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      bus_ce    <= bus_ce_nxt;
      bus_we    <= bus_we_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_sel   <= bus_sel_nxt;
      bus_wdata <= bus_wdata_nxt;
      req_ack   <= req_ack_nxt;
      req_err   <= req_err_nxt;
      req_rdata <= req_rdata_nxt;
    end
  end

endmodule
